// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one block-wide main-memory port between the
// instruction-side and data-side cache controllers.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   i_* / d_*             requester side: req, rd, wr, raddr, waddr, wdata
//                         in; rdata, ack out (ack is a one-cycle pulse,
//                         rdata valid in the ack cycle)
//   mem_start             one-cycle access start toward memory
//   mem_rd / mem_wr       owner's rd/wr, held for the whole transaction
//   mem_raddr / mem_waddr owner's addresses, registered at grant
//   mem_wdata             owner's writeback block, registered at grant
//   mem_rdata, mem_ready  memory read block and idle/complete flag
//   owner                 0 = instruction side, 1 = data side
//   busy                  transaction in flight
//
// Build option: define ARB_ROUND_ROBIN_EN for round-robin arbitration on
// simultaneous requests; otherwise the data side always wins ties.

module mem_port_arbiter #(
   parameter int ADDR_W = 32,
   parameter int BLK_W  = 128
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_req,
   input  logic              i_rd,
   input  logic              i_wr,
   input  logic [ADDR_W-1:0] i_raddr,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [BLK_W-1:0]  i_wdata,
   output logic [BLK_W-1:0]  i_rdata,
   output logic              i_ack,
   input  logic              d_req,
   input  logic              d_rd,
   input  logic              d_wr,
   input  logic [ADDR_W-1:0] d_raddr,
   input  logic [ADDR_W-1:0] d_waddr,
   input  logic [BLK_W-1:0]  d_wdata,
   output logic [BLK_W-1:0]  d_rdata,
   output logic              d_ack,
   output logic              mem_start,
   output logic              mem_rd,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_raddr,
   output logic [ADDR_W-1:0] mem_waddr,
   output logic [BLK_W-1:0]  mem_wdata,
   input  logic [BLK_W-1:0]  mem_rdata,
   input  logic              mem_ready,
   output logic              owner,
   output logic              busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT_LO,
      S_WAIT_HI,
      S_ACK
   } state_t;

   state_t r_state;

   logic              r_start;
   logic              r_mem_rd;
   logic              r_mem_wr;
   logic [ADDR_W-1:0] r_raddr;
   logic [ADDR_W-1:0] r_waddr;
   logic [BLK_W-1:0]  r_wdata;
   logic [BLK_W-1:0]  r_i_rdata;
   logic [BLK_W-1:0]  r_d_rdata;
   logic              r_i_ack;
   logic              r_d_ack;
   logic              r_owner;
   logic              r_busy;

   logic              w_pick_d;
   logic              w_any;
   logic              w_rd;
   logic              w_wr;
   logic              w_noop;
   logic              w_go;
   logic [ADDR_W-1:0] w_raddr;
   logic [ADDR_W-1:0] w_waddr;
   logic [BLK_W-1:0]  w_wdata;

`ifdef ARB_ROUND_ROBIN_EN
   // 1 = data side was granted last; a tie goes to the other side.
   logic r_last_d;

   always_comb begin
      w_pick_d = d_req & (~i_req | ~r_last_d);
   end
`else
   always_comb begin
      w_pick_d = d_req;
   end
`endif

   // Winner's request fields, selected combinationally in IDLE.
   always_comb begin
      w_any   = i_req | d_req;
      w_rd    = w_pick_d ? d_rd    : i_rd;
      w_wr    = w_pick_d ? d_wr    : i_wr;
      w_raddr = w_pick_d ? d_raddr : i_raddr;
      w_waddr = w_pick_d ? d_waddr : i_waddr;
      w_wdata = w_pick_d ? d_wdata : i_wdata;
      w_noop  = ~(w_rd | w_wr);
      // An empty request needs no memory, so it does not wait for ready.
      w_go    = w_any & (w_noop | mem_ready);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_start   <= 1'b0;
         r_mem_rd  <= 1'b0;
         r_mem_wr  <= 1'b0;
         r_raddr   <= '0;
         r_waddr   <= '0;
         r_wdata   <= '0;
         r_i_rdata <= '0;
         r_d_rdata <= '0;
         r_i_ack   <= 1'b0;
         r_d_ack   <= 1'b0;
         r_owner   <= 1'b0;
         r_busy    <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
         r_last_d  <= 1'b1;
`endif
      end else begin
         r_start <= 1'b0;
         r_i_ack <= 1'b0;
         r_d_ack <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (w_go) begin
                  r_owner <= w_pick_d;
                  r_busy  <= 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
                  r_last_d <= w_pick_d;
`endif
                  if (w_noop) begin
                     r_d_ack <= w_pick_d;
                     r_i_ack <= ~w_pick_d;
                     r_state <= S_ACK;
                  end else begin
                     r_mem_rd <= w_rd;
                     r_mem_wr <= w_wr;
                     r_raddr  <= w_raddr;
                     r_waddr  <= w_waddr;
                     r_wdata  <= w_wdata;
                     r_start  <= 1'b1;
                     r_state  <= S_ISSUE;
                  end
               end
            end
            S_ISSUE: begin
               r_state <= S_WAIT_LO;
            end
            S_WAIT_LO: begin
               if (!mem_ready) begin
                  r_state <= S_WAIT_HI;
               end
            end
            S_WAIT_HI: begin
               if (mem_ready) begin
                  if (r_mem_rd) begin
                     if (r_owner) begin
                        r_d_rdata <= mem_rdata;
                     end else begin
                        r_i_rdata <= mem_rdata;
                     end
                  end
                  r_d_ack <= r_owner;
                  r_i_ack <= ~r_owner;
                  r_state <= S_ACK;
               end
            end
            S_ACK: begin
               r_busy   <= 1'b0;
               r_mem_rd <= 1'b0;
               r_mem_wr <= 1'b0;
               r_state  <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign mem_start = r_start;
   assign mem_rd    = r_mem_rd;
   assign mem_wr    = r_mem_wr;
   assign mem_raddr = r_raddr;
   assign mem_waddr = r_waddr;
   assign mem_wdata = r_wdata;
   assign i_rdata   = r_i_rdata;
   assign d_rdata   = r_d_rdata;
   assign i_ack     = r_i_ack;
   assign d_ack     = r_d_ack;
   assign owner     = r_owner;
   assign busy      = r_busy;

endmodule
